lbist_sched: RTL

LBIST_SCHED -- requirements
Module: lbist_sched

---
 rtl/lbist_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lbist_sched.sv
// Runs ROUNDS LBIST sessions, with a per-session timeout, an idle gap between sessions and pass/fail accounting.
// test_start follows run by 1 cycle; abort reaches FIN (done pulse) the next cycle; status outputs are never stalled.
module lbist_sched #(
  parameter int ROUNDS  = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       run,
  input  logic       abort,
  output logic       test_start,
  input  logic       test_done,
  input  logic       P_F,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_cnt,
  output logic [7:0] round_idx,
  output logic       timeout_err
);

  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP - 1);
  localparam logic [7:0]  ROUND_LAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_WAIT, ST_EVAL, ST_GAP, ST_FIN
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic [7:0]  gcnt, gcnt_nxt;
  logic [7:0]  fail_nxt, round_nxt;
  logic        td_q, td_edge;
  logic        pf_q, pf_nxt;
  logic        to_q, to_nxt;
  logic        terr_nxt, pass_nxt;

  // a level left over from the previous session never looks like a new completion
  assign td_edge = test_done & ~td_q;

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    gcnt_nxt  = gcnt;
    pf_nxt    = pf_q;
    to_nxt    = to_q;
    fail_nxt  = fail_cnt;
    round_nxt = round_idx;
    terr_nxt  = timeout_err;
    pass_nxt  = pass;
    if (abort && state != ST_IDLE && state != ST_FIN) begin
      state_nxt = ST_FIN;
      pass_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run && !abort) begin
            fail_nxt  = '0;
            round_nxt = '0;
            terr_nxt  = 1'b0;
            pass_nxt  = 1'b0;
            state_nxt = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tcnt_nxt  = '0;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          // a completion edge on the last allowed cycle beats the timeout
          if (td_edge) begin
            pf_nxt    = P_F;
            to_nxt    = 1'b0;
            state_nxt = ST_EVAL;
          end else if (tcnt == TO_LAST) begin
            pf_nxt    = 1'b0;
            to_nxt    = 1'b1;
            terr_nxt  = 1'b1;
            state_nxt = ST_EVAL;
          end else begin
            tcnt_nxt = tcnt + 16'd1;
          end
        end
        ST_EVAL: begin
          if ((!pf_q || to_q) && fail_cnt != 8'hFF) fail_nxt = fail_cnt + 8'd1;
          if (round_idx == ROUND_LAST) begin
            pass_nxt  = (fail_nxt == 8'd0) && !timeout_err;
            state_nxt = ST_FIN;
          end else begin
            round_nxt = round_idx + 8'd1;
            gcnt_nxt  = '0;
            state_nxt = (GAP == 0) ? ST_LAUNCH : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gcnt == GAP_LAST) state_nxt = ST_LAUNCH;
          else gcnt_nxt = gcnt + 8'd1;
        end
        ST_FIN:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      gcnt        <= '0;
      td_q        <= 1'b0;
      pf_q        <= 1'b0;
      to_q        <= 1'b0;
      fail_cnt    <= '0;
      round_idx   <= '0;
      timeout_err <= 1'b0;
      pass        <= 1'b0;
      test_start  <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      gcnt        <= gcnt_nxt;
      td_q        <= test_done;
      pf_q        <= pf_nxt;
      to_q        <= to_nxt;
      fail_cnt    <= fail_nxt;
      round_idx   <= round_nxt;
      timeout_err <= terr_nxt;
      pass        <= pass_nxt;
      test_start  <= (state_nxt == ST_LAUNCH);
      done        <= (state_nxt == ST_FIN);
      busy        <= (state_nxt inside {ST_LAUNCH, ST_WAIT, ST_EVAL, ST_GAP});
    end
  end

endmodule
